axi_xp_map_ctrl: RTL and testbench
==================================

Name: axi_xp_map_ctrl

Overview:
- Sits in front of the buffered AXI crosspoint's slave ports and owns the crosspoint's address map (`addr_map_o`).
- Swaps in a new map only at a safe point: it quiesces all slave ports, drains every outstanding transaction, installs the staged map, then resumes traffic.
- Also caps in-flight transactions per port, so the drain time stays bounded.

Parameters:
- NumSlvPorts, 1, number of crosspoint slave ports gated.
- NumAddrRules, 1, address map rules.
- MaxTxns, 8, max outstanding reads and max outstanding writes per port; each direction counted separately.
- axi_req_t, logic, AXI4+ATOP request struct.
- axi_resp_t, logic, AXI4+ATOP response struct.
- rule_t, axi_pkg::xbar_rule_64_t, address rule type.

Ports:
- clk_i  in  1  clock; rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- slv_req_i  in  NumSlvPorts x axi_req_t  upstream requests.
- slv_resp_o  out  NumSlvPorts x axi_resp_t  upstream responses.
- mst_req_o  out  NumSlvPorts x axi_req_t  to crosspoint slave ports.
- mst_resp_i  in  NumSlvPorts x axi_resp_t  from crosspoint.
- cfg_req_i  in  1  map update request; held high until cfg_ack_o.
- cfg_map_i  in  NumAddrRules x rule_t  new map; stable while cfg_req_i is high.
- cfg_ack_o  out  1  one-cycle pulse when the new map is active.
- addr_map_o  out  NumAddrRules x rule_t  registered map driven to the crosspoint.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Pass-through: everything passes combinationally except the AW/AR valid toward the crosspoint and the AW/AR ready toward upstream. Zero added latency.
- Gating: when a port's AW is gated, mst aw_valid=0 and slv aw_ready=0. AR gating is identical.
- When AW is gated:
  - no gating is applied while port aw_pend=1; aw_pend is set when mst aw_valid=1 and aw_ready=0 in a cycle, and cleared on handshake. A presented valid is never withdrawn.
  - otherwise, AW is gated when state is not IDLE, or when wr_cnt==MaxTxns.
- When AR is gated: same rule, using ar_pend and rd_cnt.
- Counters: wr_cnt and rd_cnt per port, width $clog2(MaxTxns+1).
  - wr_cnt: +1 on mst AW handshake; -1 on slv B handshake.
  - rd_cnt: +1 on mst AR handshake; +1 on an AW handshake with atop[5]=1 (ATOP read response); -1 on an R handshake with last=1.
  - Both counters can increment on the same cycle from different events.
  - Simultaneous inc and dec leaves the counter unchanged.
  - Underflow never occurs with a legal crosspoint.
- FSM:
  - IDLE: on cfg_req_i -> BLOCK.
  - BLOCK: gating active. When all aw_pend/ar_pend are 0 -> DRAIN.
  - DRAIN: when all wr_cnt and rd_cnt are 0 and no W beat is pending -> SWAP. W pending means a per-port W-owed counter, incremented on AW handshake and decremented on W last handshake, is nonzero.
  - SWAP: addr_map_o <= cfg_map_i, cfg_ack_o=1 for this cycle -> ACK.
  - ACK: wait for cfg_req_i low -> IDLE. Gating stays active until cfg_req_i drops.
- Reset: state=IDLE; all counters and pend flags 0; addr_map_o='0; cfg_ack_o=0; busy_o=0. Gating is inactive, so the mst/slv outputs are pure pass-through.
- Reset mid-drain: the FSM aborts to IDLE and the map is cleared. Upstream and crosspoint must be reset together.
- Boundary cases:
  - cfg_req_i falling before ACK is a protocol error (assertion). The FSM still completes.
  - A cfg_req_i already high on the cycle leaving ACK is not re-serviced until it falls.

Optional Feature:
- Macro: AXI_XP_MAP_CTRL_TIMEOUT_EN.
- With it defined:
  - add parameter DrainTimeout (default 1024) and output drain_err_o (1 bit, sticky, cleared by reset).
  - the DRAIN cycle count reaching DrainTimeout sets drain_err_o.
  - the FSM keeps waiting; there is no forced swap.
- Without it: no timeout counter and no drain_err_o port.

Decomposition:
- Package axi_xp_map_ctrl_pkg holds the FSM state enum (IDLE, BLOCK, DRAIN, SWAP, ACK).
- Counter width is a localparam in the module.
- Sub-module axi_xp_port_gate handles one port's gating, pend flags, wr/rd/W-owed counters and idle flag. It is instantiated NumSlvPorts times in a generate loop.
- The top holds the FSM, map register and optional timeout.

Test Plan:
- Reset with rst_i=1 for 2 cycles -> addr_map_o=0, cfg_ack_o=0, busy_o=0; AW/AR pass through with aw_ready mirrored.
- Port 0: 8 AWs with B held off, MaxTxns=8 -> 9th AW sees aw_ready=0. One B accepted -> next AW accepted the following cycle.
- Port 1: 3 reads in flight (len=3), then cfg_req_i=1 -> new AR blocked. Map updates only after the 3rd R last; cfg_ack_o pulses exactly 1 cycle; addr_map_o equals cfg_map_i.
- Port 0: AW valid stalled by crosspoint ready=0 when cfg_req_i rises -> mst aw_valid stays 1 until handshake, then the FSM enters DRAIN.
- Port 2: ATOP AW with atop[5]=1 -> swap waits for both B and R last, in either order.
- With AXI_XP_MAP_CTRL_TIMEOUT_EN and DrainTimeout=16: B withheld 20 cycles -> drain_err_o=1 at DRAIN cycle 16. B released -> swap completes and drain_err_o stays 1.

Source files
------------

// File: rtl/axi_xp_map_ctrl_pkg.sv
// Shared types for the crosspoint address-map controller: FSM states, the
// AXI4+ATOP channel structs used as default port types, and the map rule type.
package axi_xp_map_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      BLOCK = 3'd1,
      DRAIN = 3'd2,
      SWAP  = 3'd3,
      ACK   = 3'd4
   } map_state_e;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [5:0]  atop;
   } aw_chan_t;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } w_chan_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_chan_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
   } ar_chan_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } axi_req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    w_ready;
      b_chan_t b;
      logic    b_valid;
      logic    ar_ready;
      r_chan_t r;
      logic    r_valid;
   } axi_resp_t;

   typedef struct packed {
      logic [31:0] idx;
      logic [63:0] start_addr;
      logic [63:0] end_addr;
   } xbar_rule_64_t;

endpackage

// File: rtl/axi_xp_port_gate.sv
// One crosspoint slave port: AW/AR admission gating, stall-pending flags and
// the read/write/W-owed outstanding counters that decide when the port is idle.
module axi_xp_port_gate
   import axi_xp_map_ctrl_pkg::*;
#(
   parameter int unsigned MaxTxns = 8,
   parameter type axi_req_t  = axi_xp_map_ctrl_pkg::axi_req_t,
   parameter type axi_resp_t = axi_xp_map_ctrl_pkg::axi_resp_t
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      gate_i,
   input  axi_req_t  slv_req_i,
   output axi_resp_t slv_resp_o,
   output axi_req_t  mst_req_o,
   input  axi_resp_t mst_resp_i,
   output logic      pend_o,
   output logic      idle_o
);

   localparam int unsigned CntW = $clog2(MaxTxns + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(MaxTxns);

   logic [CntW-1:0] wr_cnt_q, rd_cnt_q, w_owed_q;
   logic            aw_pend_q, ar_pend_q;
   logic            aw_gate, ar_gate;
   logic            aw_hs, ar_hs, b_hs, w_last_hs, r_last_hs, aw_atop_rd;

   // A valid already shown to the crosspoint must stay up, so a pending
   // request overrides both the FSM gate and the in-flight cap.
   always_comb begin
      aw_gate    = !aw_pend_q && (gate_i || (wr_cnt_q == CntMax));
      ar_gate    = !ar_pend_q && (gate_i || (rd_cnt_q == CntMax));
      mst_req_o  = slv_req_i;
      slv_resp_o = mst_resp_i;
      if (aw_gate) begin
         mst_req_o.aw_valid  = 1'b0;
         slv_resp_o.aw_ready = 1'b0;
      end
      if (ar_gate) begin
         mst_req_o.ar_valid  = 1'b0;
         slv_resp_o.ar_ready = 1'b0;
      end
   end

   assign aw_hs      = mst_req_o.aw_valid & mst_resp_i.aw_ready;
   assign ar_hs      = mst_req_o.ar_valid & mst_resp_i.ar_ready;
   assign b_hs       = mst_resp_i.b_valid & slv_req_i.b_ready;
   assign w_last_hs  = slv_req_i.w_valid & mst_resp_i.w_ready & slv_req_i.w.last;
   assign r_last_hs  = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
   assign aw_atop_rd = aw_hs & slv_req_i.aw.atop[5];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         w_owed_q  <= '0;
         aw_pend_q <= 1'b0;
         ar_pend_q <= 1'b0;
      end else begin
         wr_cnt_q <= wr_cnt_q + CntW'(aw_hs) - CntW'(b_hs);
         // Atomics with a read response owe an R burst as well as a B.
         rd_cnt_q <= rd_cnt_q + CntW'(ar_hs) + CntW'(aw_atop_rd) - CntW'(r_last_hs);
         w_owed_q <= w_owed_q + CntW'(aw_hs) - CntW'(w_last_hs);
         if (aw_hs)
            aw_pend_q <= 1'b0;
         else if (mst_req_o.aw_valid)
            aw_pend_q <= 1'b1;
         if (ar_hs)
            ar_pend_q <= 1'b0;
         else if (mst_req_o.ar_valid)
            ar_pend_q <= 1'b1;
      end
   end

   assign pend_o = aw_pend_q | ar_pend_q;
   assign idle_o = (wr_cnt_q == '0) && (rd_cnt_q == '0) && (w_owed_q == '0);

endmodule

// File: rtl/axi_xp_map_ctrl.sv
// Crosspoint address-map controller: quiesces and drains all slave ports before
// installing a staged map. Optional drain watchdog: AXI_XP_MAP_CTRL_TIMEOUT_EN.
//
//  state | meaning
//  IDLE  | traffic flows, map stable, waiting for cfg_req_i
//  BLOCK | new AW/AR refused; waiting for stalled valids to handshake
//  DRAIN | waiting for every read, write and owed W beat to complete
//  SWAP  | staged map loaded this cycle
//  ACK   | new map active; gating held until cfg_req_i drops
module axi_xp_map_ctrl
   import axi_xp_map_ctrl_pkg::*;
#(
   parameter int unsigned NumSlvPorts  = 1,
   parameter int unsigned NumAddrRules = 1,
   parameter int unsigned MaxTxns      = 8,
`ifdef AXI_XP_MAP_CTRL_TIMEOUT_EN
   parameter int unsigned DrainTimeout = 1024,
`endif
   parameter type axi_req_t  = axi_xp_map_ctrl_pkg::axi_req_t,
   parameter type axi_resp_t = axi_xp_map_ctrl_pkg::axi_resp_t,
   parameter type rule_t     = axi_xp_map_ctrl_pkg::xbar_rule_64_t
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  axi_req_t  [NumSlvPorts-1:0]  slv_req_i,
   output axi_resp_t [NumSlvPorts-1:0]  slv_resp_o,
   output axi_req_t  [NumSlvPorts-1:0]  mst_req_o,
   input  axi_resp_t [NumSlvPorts-1:0]  mst_resp_i,
   input  logic                         cfg_req_i,
   input  rule_t     [NumAddrRules-1:0] cfg_map_i,
   output logic                         cfg_ack_o,
   output rule_t     [NumAddrRules-1:0] addr_map_o,
   output logic                         busy_o
`ifdef AXI_XP_MAP_CTRL_TIMEOUT_EN
   ,
   output logic                         drain_err_o
`endif
);

   map_state_e                   state_q, state_d;
   logic                         gate;
   logic [NumSlvPorts-1:0]       pend, idle;
   rule_t [NumAddrRules-1:0]     map_q;
   logic                         ack_q;

   for (genvar g = 0; g < NumSlvPorts; g++) begin : g_port
      axi_xp_port_gate #(
         .MaxTxns    (MaxTxns),
         .axi_req_t  (axi_req_t),
         .axi_resp_t (axi_resp_t)
      ) u_gate (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .gate_i     (gate),
         .slv_req_i  (slv_req_i[g]),
         .slv_resp_o (slv_resp_o[g]),
         .mst_req_o  (mst_req_o[g]),
         .mst_resp_i (mst_resp_i[g]),
         .pend_o     (pend[g]),
         .idle_o     (idle[g])
      );
   end

   always_comb begin
      state_d = state_q;
      gate    = (state_q != IDLE);
      unique case (state_q)
         IDLE:    if (cfg_req_i) state_d = BLOCK;
         BLOCK:   if (pend == '0) state_d = DRAIN;
         DRAIN:   if (&idle) state_d = SWAP;
         SWAP:    state_d = ACK;
         ACK:     if (!cfg_req_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Ack is registered alongside the map so it coincides with the new map.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         map_q   <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= (state_q == SWAP);
         if (state_q == SWAP)
            map_q <= cfg_map_i;
      end
   end

   assign addr_map_o = map_q;
   assign cfg_ack_o  = ack_q;
   assign busy_o     = (state_q != IDLE);

`ifdef AXI_XP_MAP_CTRL_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(DrainTimeout + 1);

   logic [TmoW-1:0] tmo_cnt_q;
   logic            drain_err_q;

   // Down-counter reloads outside DRAIN; the error flag is sticky and the
   // FSM keeps waiting, so a late drain still completes normally.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tmo_cnt_q   <= TmoW'(DrainTimeout);
         drain_err_q <= 1'b0;
      end else if (state_q != DRAIN) begin
         tmo_cnt_q <= TmoW'(DrainTimeout);
      end else if (tmo_cnt_q != '0) begin
         tmo_cnt_q <= tmo_cnt_q - 1'b1;
         if (tmo_cnt_q == TmoW'(1))
            drain_err_q <= 1'b1;
      end
   end

   assign drain_err_o = drain_err_q;
`endif

`ifndef SYNTHESIS
   cfg_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
      (state_q inside {BLOCK, DRAIN, SWAP}) |-> cfg_req_i);
`endif

endmodule

// File: tb/tb_axi_xp_map_ctrl.sv
// Directed bench for axi_xp_map_ctrl: stimulus pushes expected handshakes and
// maps into scoreboard queues; a negedge monitor pops and compares them.
module tb_axi_xp_map_ctrl;
   import axi_xp_map_ctrl_pkg::*;

   localparam int NP = 3;
   localparam int NR = 2;

   typedef xbar_rule_64_t [NR-1:0] map_t;
   typedef struct {
      int          kind;   // 0 = AW, 1 = AR
      int          port;
      logic [31:0] addr;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  rst;
   axi_req_t  [NP-1:0]    slv_req;
   axi_resp_t [NP-1:0]    slv_resp;
   axi_req_t  [NP-1:0]    mst_req;
   axi_resp_t [NP-1:0]    mst_resp;
   logic                  cfg_req;
   map_t                  cfg_map;
   logic                  cfg_ack;
   map_t                  addr_map;
   logic                  busy;
`ifdef AXI_XP_MAP_CTRL_TIMEOUT_EN
   logic                  drain_err;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   map_t exp_map_q[$];
   logic ack_prev = 1'b0;

   always #5 clk = ~clk;

   axi_xp_map_ctrl #(
      .NumSlvPorts  (NP),
      .NumAddrRules (NR),
      .MaxTxns      (8)
`ifdef AXI_XP_MAP_CTRL_TIMEOUT_EN
      , .DrainTimeout (16)
`endif
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .slv_req_i   (slv_req),
      .slv_resp_o  (slv_resp),
      .mst_req_o   (mst_req),
      .mst_resp_i  (mst_resp),
      .cfg_req_i   (cfg_req),
      .cfg_map_i   (cfg_map),
      .cfg_ack_o   (cfg_ack),
      .addr_map_o  (addr_map),
      .busy_o      (busy)
`ifdef AXI_XP_MAP_CTRL_TIMEOUT_EN
      , .drain_err_o (drain_err)
`endif
   );

   task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic map_t mk_map(input logic [31:0] s);
      map_t m;
      m[0].idx = 32'd0;
      m[0].start_addr = {32'h0, s};
      m[0].end_addr   = {32'h0, s + 32'h1000};
      m[1].idx = 32'd1;
      m[1].start_addr = {32'h0, s + 32'h1000};
      m[1].end_addr   = {32'h0, s + 32'h2000};
      return m;
   endfunction

   // Scoreboard monitor
   task automatic sb_pop(input int kind, input int p, input logic [31:0] a);
      exp_t e;
      if (exp_q.size() == 0) begin
         chk("unexpected_hs", 1, 0);
      end else begin
         e = exp_q.pop_front();
         chk("hs_kind", kind, e.kind);
         chk("hs_port", p, e.port);
         chk("hs_addr", a, e.addr);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         for (int p = 0; p < NP; p++) begin
            if (mst_req[p].aw_valid && mst_resp[p].aw_ready) sb_pop(0, p, mst_req[p].aw.addr);
            if (mst_req[p].ar_valid && mst_resp[p].ar_ready) sb_pop(1, p, mst_req[p].ar.addr);
         end
         if (ack_prev) chk("ack_width", cfg_ack, 0);
         if (cfg_ack) begin
            if (exp_map_q.size() == 0) chk("unexpected_ack", 1, 0);
            else chk("ack_map", addr_map, exp_map_q.pop_front());
         end
         ack_prev = cfg_ack;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_aw_hs(input int p);
      int n = 0;
      #1;
      while (!(mst_req[p].aw_valid && mst_resp[p].aw_ready) && n < 200) begin
         @(posedge clk); #2; n++;
      end
      chk("aw_hs_bound", n < 200, 1);
      tick();
      slv_req[p].aw_valid = 1'b0;
      mst_resp[p].aw_ready = 1'b0;
   endtask

   task automatic wait_ar_hs(input int p);
      int n = 0;
      #1;
      while (!(mst_req[p].ar_valid && mst_resp[p].ar_ready) && n < 200) begin
         @(posedge clk); #2; n++;
      end
      chk("ar_hs_bound", n < 200, 1);
      tick();
      slv_req[p].ar_valid = 1'b0;
      mst_resp[p].ar_ready = 1'b0;
   endtask

   task automatic send_aw(input int p, input logic [31:0] a, input logic [5:0] at);
      slv_req[p].aw_valid = 1'b1;
      slv_req[p].aw.addr  = a;
      slv_req[p].aw.atop  = at;
      mst_resp[p].aw_ready = 1'b1;
      exp_q.push_back('{0, p, a});
      wait_aw_hs(p);
   endtask

   task automatic send_ar(input int p, input logic [31:0] a, input logic [7:0] len);
      slv_req[p].ar_valid = 1'b1;
      slv_req[p].ar.addr  = a;
      slv_req[p].ar.len   = len;
      mst_resp[p].ar_ready = 1'b1;
      exp_q.push_back('{1, p, a});
      wait_ar_hs(p);
   endtask

   task automatic send_w(input int p);
      slv_req[p].w_valid = 1'b1; slv_req[p].w.last = 1'b1; mst_resp[p].w_ready = 1'b1;
      tick();
      slv_req[p].w_valid = 1'b0; mst_resp[p].w_ready = 1'b0;
   endtask

   task automatic send_b(input int p);
      mst_resp[p].b_valid = 1'b1; slv_req[p].b_ready = 1'b1;
      tick();
      mst_resp[p].b_valid = 1'b0; slv_req[p].b_ready = 1'b0;
   endtask

   task automatic send_r(input int p, input logic last);
      mst_resp[p].r_valid = 1'b1; mst_resp[p].r.last = last; slv_req[p].r_ready = 1'b1;
      tick();
      mst_resp[p].r_valid = 1'b0; slv_req[p].r_ready = 1'b0;
   endtask

   task automatic request(input map_t m);
      cfg_req = 1'b1;
      cfg_map = m;
      exp_map_q.push_back(m);
   endtask

   task automatic wait_ack(output int n);
      n = 0;
      while (!cfg_ack && n < 100) begin
         tick(); n++;
      end
      chk("ack_seen", cfg_ack, 1);
   endtask

   task automatic release_req();
      cfg_req = 1'b0;
      tick();
      chk("busy_after_ack", busy, 0);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      slv_req = '0;
      mst_resp = '0;
      cfg_req = 1'b0;
      cfg_map = '0;

      // Reset: pass-through with mirrored ready
      tick();
      slv_req[0].aw_valid = 1'b1;
      #1 chk("rst_aw_valid_pass", mst_req[0].aw_valid, 1);
      chk("rst_aw_ready_low", slv_resp[0].aw_ready, 0);
      mst_resp[0].aw_ready = 1'b1;
      #1 chk("rst_aw_ready_high", slv_resp[0].aw_ready, 1);
      slv_req[0].ar_valid = 1'b1; mst_resp[0].ar_ready = 1'b1;
      #1 chk("rst_ar_ready_pass", slv_resp[0].ar_ready, 1);
      slv_req = '0; mst_resp = '0;
      tick();
      chk("rst_addr_map", addr_map, 0);
      chk("rst_cfg_ack", cfg_ack, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      tick();

      // Port 0: in-flight cap at MaxTxns writes
      for (int i = 0; i < 8; i++) send_aw(0, 32'h100 + i * 32'h10, 6'd0);
      slv_req[0].aw_valid = 1'b1; slv_req[0].aw.addr = 32'h200; slv_req[0].aw.atop = 6'd0;
      mst_resp[0].aw_ready = 1'b1;
      exp_q.push_back('{0, 0, 32'h200});
      #1 chk("cap_aw_ready", slv_resp[0].aw_ready, 0);
      chk("cap_mst_aw_valid", mst_req[0].aw_valid, 0);
      tick();
      chk("cap_aw_ready_hold", slv_resp[0].aw_ready, 0);
      mst_resp[0].b_valid = 1'b1; slv_req[0].b_ready = 1'b1;
      tick();
      mst_resp[0].b_valid = 1'b0; slv_req[0].b_ready = 1'b0;
      #1 chk("cap_released", slv_resp[0].aw_ready, 1);
      tick();
      slv_req[0].aw_valid = 1'b0; mst_resp[0].aw_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         slv_req[0].w_valid = 1'b1; slv_req[0].w.last = 1'b1; mst_resp[0].w_ready = 1'b1;
         mst_resp[0].b_valid = (i < 8); slv_req[0].b_ready = 1'b1;
         tick();
      end
      slv_req[0] = '0; mst_resp[0] = '0;

      // Port 1: map swap waits for three 4-beat reads
      for (int i = 0; i < 3; i++) send_ar(1, 32'h1000 + i * 32'h40, 8'd3);
      request(mk_map(32'h8000_0000));
      tick();
      slv_req[1].ar_valid = 1'b1; slv_req[1].ar.addr = 32'h1400; slv_req[1].ar.len = 8'd0;
      mst_resp[1].ar_ready = 1'b1;
      exp_q.push_back('{1, 1, 32'h1400});
      #1 chk("blk_ar_ready", slv_resp[1].ar_ready, 0);
      chk("blk_mst_ar_valid", mst_req[1].ar_valid, 0);
      chk("blk_busy", busy, 1);
      tick();
      for (int i = 0; i < 12; i++) begin
         mst_resp[1].r_valid = 1'b1; mst_resp[1].r.last = (i % 4 == 3); slv_req[1].r_ready = 1'b1;
         if (i == 11) begin
            chk("map_before_last_r", addr_map, 0);
            chk("ack_before_last_r", cfg_ack, 0);
         end
         tick();
      end
      mst_resp[1].r_valid = 1'b0; slv_req[1].r_ready = 1'b0;
      wait_ack(n);
      chk("swap_latency", n, 2);
      chk("map_installed", addr_map, mk_map(32'h8000_0000));
      chk("ack_state_ar_gated", slv_resp[1].ar_ready, 0);
      release_req();
      wait_ar_hs(1);
      send_r(1, 1'b1);

      // Port 0: stalled AW is held through BLOCK until handshake
      slv_req[0].aw_valid = 1'b1; slv_req[0].aw.addr = 32'h300; slv_req[0].aw.atop = 6'd0;
      exp_q.push_back('{0, 0, 32'h300});
      tick();
      request(mk_map(32'h9000_0000));
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("aw_valid_held", mst_req[0].aw_valid, 1);
      end
      chk("held_busy", busy, 1);
      mst_resp[0].aw_ready = 1'b1;
      #1 chk("pend_ready_pass", slv_resp[0].aw_ready, 1);
      tick();
      slv_req[0].aw_valid = 1'b0; mst_resp[0].aw_ready = 1'b0;
      send_w(0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("no_ack_b_owed", cfg_ack, 0);
      end
      send_b(0);
      wait_ack(n);
      release_req();

      // Port 2: atomic owes both B and R, completed in either order
      for (int ord = 0; ord < 2; ord++) begin
         send_aw(2, 32'h2000 + ord * 32'h100, 6'b100000);
         send_w(2);
         request(mk_map(32'hA000_0000 + ord * 32'h10_0000));
         tick(); tick();
         if (ord == 0) send_r(2, 1'b1); else send_b(2);
         for (int k = 0; k < 4; k++) begin
            tick();
            chk("atop_no_ack", cfg_ack, 0);
         end
         chk("atop_map_old", addr_map, (ord == 0) ? mk_map(32'h9000_0000) : mk_map(32'hA000_0000));
         if (ord == 0) send_b(2); else send_r(2, 1'b1);
         wait_ack(n);
         release_req();
      end

`ifdef AXI_XP_MAP_CTRL_TIMEOUT_EN
      send_aw(0, 32'h400, 6'd0);
      send_w(0);
      request(mk_map(32'hB000_0000));
      for (int k = 0; k < 12; k++) tick();
      chk("tmo_err_early", drain_err, 0);
      for (int k = 0; k < 8; k++) tick();
      chk("tmo_err_set", drain_err, 1);
      send_b(0);
      wait_ack(n);
      release_req();
      chk("tmo_err_sticky", drain_err, 1);
`endif

      tick(); tick();
      chk("sb_hs_empty", exp_q.size(), 0);
      chk("sb_map_empty", exp_map_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
